uart_tx_maj: RTL

UART_TX_MAJ -- requirements
Module: uart_tx_maj

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_tx_maj.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART FSM state encoding and clog2 helper.
// ST_PARITY is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

  // Ceiling log2 with a minimum of 1, so counters are never zero width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned p = 1; p < value; p = p << 1) width++;
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time down-counter: reloads to CLKS_PER_BIT-1 and ticks when the count is 0.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic tick
);

  localparam int unsigned CW = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_maj.sv
// UART transmitter, LSB first, tx registered so each bit level is glitch-free.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx_maj
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx
);

  localparam int unsigned IW = clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 reload;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .reload(reload),
    .tick  (tick)
  );

  // tx_d is the level for the next bit, so it is set on the same edge as the state change.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    reload  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (data_valid) begin
          data_d  = data_in;
          idx_d   = '0;
          tx_d    = 1'b0;
          reload  = 1'b1;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d    = data_q[0];
          idx_d   = '0;
          reload  = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          reload = 1'b1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            // Word shifts right so the next payload bit is always at index 1.
            idx_d  = idx_q + 1'b1;
            data_d = data_q >> 1;
            tx_d   = data_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          reload  = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          tx_d    = 1'b1;
          reload  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q != ST_IDLE);
  assign tx    = tx_q;

endmodule
